// File: rtl/bin2bcd_display_ctrl_if.sv
// Handshake and display bundle between a value producer and bin2bcd_display_ctrl.
// master = producer side, slave = converter side.
interface bin2bcd_display_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int NDIG  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_value;
  logic [4*NDIG-1:0] bcd_out;
  logic              neg_out;
  logic              out_valid;
  logic              busy;

  modport master (
    output in_valid, in_value,
    input  in_ready, bcd_out, neg_out, out_valid, busy
  );

  modport slave (
    input  in_valid, in_value,
    output in_ready, bcd_out, neg_out, out_valid, busy
  );
endinterface

// File: rtl/bin2bcd_display_ctrl.sv
// Serial double-dabble binary-to-BCD converter feeding a bank of 7-segment decoders.
// Optional macro BCD_BLANK_LEADING_EN: leading zero digits (above digit 0) are written as 4'hF (dark).
module bin2bcd_display_ctrl #(
  parameter int WIDTH  = 16,
  parameter int NDIG   = 5,
  parameter int SIGNED = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  bin2bcd_display_ctrl_if.slave   bus
);

  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(WIDTH + 1);

  // 10^NDIG > 2^WIDTH  <=>  NDIG*log2(10) > WIDTH; log2(10) truncated so the test errs strict.
  localparam bit NDIG_OK = (longint'(NDIG) * 64'sd3321928) > (longint'(WIDTH) * 64'sd1000000);

  generate
    if (!NDIG_OK) begin : g_ndig_chk
      $error("bin2bcd_display_ctrl: NDIG too small to hold 2^WIDTH");
    end
    if (WIDTH < 2) begin : g_width_chk
      $error("bin2bcd_display_ctrl: WIDTH must be at least 2");
    end
  endgenerate

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // One double-dabble iteration: correct every digit, then shift in the next magnitude bit.
  function automatic logic [BW-1:0] dabble_step(input logic [BW-1:0] s, input logic b);
    logic [BW-1:0] adj;
    adj = s;
    for (int k = 0; k < NDIG; k++) begin
      adj[4*k +: 4] = add3(s[4*k +: 4]);
    end
    return {adj[BW-2:0], b};
  endfunction

  function automatic logic [BW-1:0] blank_leading(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
`ifdef BCD_BLANK_LEADING_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int k = NDIG - 1; k >= 1; k--) begin
        if (lead && (s[4*k +: 4] == 4'd0)) begin
          r[4*k +: 4] = 4'hF;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
    return r;
  endfunction

  localparam logic [BW-1:0] BCD_RST = blank_leading('0);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]    scratch;
  logic             sign;
  logic [BW-1:0]    scratch_nxt;
  logic             sign_in;
  logic [BW-1:0]    bcd_r;
  logic             neg_r;
  logic             out_valid_r;
  logic             busy_r;

  assign sign_in     = (SIGNED != 0) && bus.in_value[WIDTH-1];
  assign scratch_nxt = dabble_step(scratch, mag[WIDTH-1]);

  // Scratch/magnitude are pure datapath and only meaningful while in SHIFT, so they carry no reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      neg_r       <= 1'b0;
      bcd_r       <= BCD_RST;
    end else begin
      out_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mag     <= sign_in ? -bus.in_value : bus.in_value;
            sign    <= sign_in;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            busy_r  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          mag     <= mag << 1;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd_r       <= blank_leading(scratch_nxt);
            neg_r       <= sign;
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = reset_n & ~busy_r;
  assign bus.busy      = busy_r;
  assign bus.out_valid = out_valid_r;
  assign bus.bcd_out   = bcd_r;
  assign bus.neg_out   = neg_r;

endmodule

// File: tb/tb_bin2bcd_display_ctrl.sv
// Bench for bin2bcd_display_ctrl: an unsigned and a signed instance driven by the same stimulus,
// each compared against a decimal-arithmetic reference model.
module tb_bin2bcd_display_ctrl;

  localparam int WIDTH = 16;
  localparam int NDIG  = 5;

`ifdef BCD_BLANK_LEADING_EN
  localparam logic [19:0] RST_BCD = 20'hFFFF0;
`else
  localparam logic [19:0] RST_BCD = 20'h00000;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_value = 16'd0;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clock = ~clock;

  bin2bcd_display_ctrl_if #(.WIDTH(WIDTH), .NDIG(NDIG)) bus_u ();
  bin2bcd_display_ctrl_if #(.WIDTH(WIDTH), .NDIG(NDIG)) bus_s ();

  assign bus_u.in_valid = in_valid;
  assign bus_u.in_value = in_value;
  assign bus_s.in_valid = in_valid;
  assign bus_s.in_value = in_value;

  bin2bcd_display_ctrl #(.WIDTH(WIDTH), .NDIG(NDIG), .SIGNED(0)) dut_u (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_u)
  );

  bin2bcd_display_ctrl #(.WIDTH(WIDTH), .NDIG(NDIG), .SIGNED(1)) dut_s (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Reference: {neg, bcd} from decimal arithmetic on the magnitude.
  function automatic logic [20:0] ref_result(input logic [15:0] v, input bit sgn);
    int          mag;
    int          msd;
    int          d;
    logic [19:0] bcd;
    bit          neg;
    neg = sgn && v[15];
    mag = neg ? 65536 - int'(v) : int'(v);
    bcd = '0;
    msd = 0;
    for (int k = 0; k < NDIG; k++) begin
      d = mag % 10;
      mag = mag / 10;
      bcd[4*k +: 4] = 4'(d);
      if (d != 0) msd = k;
    end
`ifdef BCD_BLANK_LEADING_EN
    for (int k = 1; k < NDIG; k++) begin
      if (k > msd) bcd[4*k +: 4] = 4'hF;
    end
`endif
    return {neg, bcd};
  endfunction

  // Caller has in_valid=1/in_value=v set, #1 after an edge, DUT idle.
  task automatic do_conv(input logic [15:0] v, input bit junk, input bit chain,
                         input logic [15:0] nxt, input string tag);
    int          n;
    bit          got;
    logic [19:0] prev_u;
    logic [20:0] r;
    prev_u = bus_u.bcd_out;
    check({tag, " in_ready"}, 32'(bus_u.in_ready), 32'd1);
    @(posedge clock); #1;
    check({tag, " busy"}, 32'(bus_u.busy), 32'd1);
    check({tag, " ovld_low"}, 32'(bus_u.out_valid | bus_s.out_valid), 32'd0);
    if (junk) in_value = 16'd777;
    else in_valid = 1'b0;
    n = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clock); #1;
      n++;
      if (n == 8) check({tag, " hold"}, 32'(bus_u.bcd_out), 32'(prev_u));
      if (bus_u.out_valid) got = 1'b1;
    end
    check({tag, " latency"}, 32'(n), 32'(WIDTH));
    r = ref_result(v, 1'b0);
    check({tag, " bcd_u"}, 32'(bus_u.bcd_out), 32'(r[19:0]));
    check({tag, " neg_u"}, 32'(bus_u.neg_out), 32'(r[20]));
    r = ref_result(v, 1'b1);
    check({tag, " bcd_s"}, 32'(bus_s.bcd_out), 32'(r[19:0]));
    check({tag, " neg_s"}, 32'(bus_s.neg_out), 32'(r[20]));
    check({tag, " ovld_s"}, 32'(bus_s.out_valid), 32'd1);
    check({tag, " ready_done"}, 32'(bus_u.in_ready), 32'd1);
    if (chain) begin
      in_valid = 1'b1;
      in_value = nxt;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic start_conv(input logic [15:0] v, input string tag);
    in_valid = 1'b1;
    in_value = v;
    do_conv(v, 1'b0, 1'b0, 16'd0, tag);
  endtask

  initial begin
    logic [15:0] rv;
    // Reset behaviour, with in_valid asserted to show it is ignored.
    in_valid = 1'b1;
    in_value = 16'd5;
    repeat (3) @(posedge clock);
    #1;
    check("rst bcd", 32'(bus_u.bcd_out), 32'(RST_BCD));
    check("rst neg", 32'(bus_s.neg_out), 32'd0);
    check("rst ovld", 32'(bus_u.out_valid), 32'd0);
    check("rst busy", 32'(bus_u.busy | bus_s.busy), 32'd0);
    check("rst ready", 32'(bus_u.in_ready), 32'd0);
    in_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    check("post rst ready", 32'(bus_u.in_ready), 32'd1);

    start_conv(16'd0, "zero");
    start_conv(16'd65535, "max");
    start_conv(16'd1007, "1007");
    start_conv(16'h8000, "8000");
    start_conv(16'hFFFF, "ffff");
    start_conv(16'h7FFF, "7fff");

    // Back-to-back with junk on in_value during SHIFT.
    in_valid = 1'b1;
    in_value = 16'd1234;
    do_conv(16'd1234, 1'b1, 1'b1, 16'd9, "b2b 1234");
    do_conv(16'd9, 1'b1, 1'b0, 16'd0, "b2b 9");

    // Reset arriving at the 8th SHIFT edge of 4321.
    in_valid = 1'b1;
    in_value = 16'd4321;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (7) begin
      @(posedge clock); #1;
    end
    reset_n = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      check("abort ovld", 32'(bus_u.out_valid | bus_s.out_valid), 32'd0);
    end
    check("abort bcd", 32'(bus_u.bcd_out), 32'(RST_BCD));
    check("abort neg", 32'(bus_s.neg_out), 32'd0);
    check("abort ready", 32'(bus_u.in_ready), 32'd0);
    check("abort busy", 32'(bus_u.busy), 32'd0);
    reset_n = 1'b1;
    #1;
    check("abort ready_up", 32'(bus_u.in_ready), 32'd1);

    // Stability after a completed result.
    start_conv(16'd40, "forty");
    repeat (50) begin
      @(posedge clock); #1;
      check("stable bcd", 32'(bus_u.bcd_out), 32'(ref_result(16'd40, 1'b0) & 21'h0FFFFF));
      check("stable ovld", 32'(bus_u.out_valid), 32'd0);
      check("stable ready", 32'(bus_u.in_ready), 32'd1);
    end

    // Randomized values, sometimes with junk during SHIFT.
    for (int i = 0; i < 24; i++) begin
      rv = 16'($urandom_range(0, 65535));
      in_valid = 1'b1;
      in_value = rv;
      do_conv(rv, 1'($urandom_range(0, 1)), 1'b0, 16'd0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bin2bcd_display_ctrl.md
Name: bin2bcd_display_ctrl

Overview:
- Sequential binary-to-BCD converter and scheduler that feeds the team's 7-segment decoder instances.
- Accepts one WIDTH-bit value per valid/ready handshake and converts it serially by double-dabble (shift-and-add-3), one bit per clock.
- Presents NDIG latched 4-bit BCD digits, one nibble per decoder instance, plus a sign flag for a minus-segment display.
- Sits between the CPU output register and the HEX decoder bank.

Parameters:
- WIDTH, 16, input value width in bits.
- NDIG, 5, number of BCD digits. Must satisfy 10^NDIG > 2^WIDTH; elaboration fails otherwise.
- SIGNED, 0, 1 = in_value is two's complement and the magnitude is converted; 0 = unsigned.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_value is offered.
- in_ready  out  1  block idle, can accept a value.
- in_value  in  WIDTH  value to convert.
- bcd_out  out  4*NDIG  digit k at [4k+3:4k], k=0 is the least-significant digit.
- neg_out  out  1  latched sign; 1 only when SIGNED=1 and the value was negative.
- out_valid  out  1  one-cycle pulse, new bcd_out/neg_out available.
- busy  out  1  conversion in progress (equals ~in_ready out of reset).

Behaviour:
- Interface: one clock; reset is synchronous and active-low. All state changes on the rising edge of clock.
- Reset (reset_n low at an edge):
  - state=IDLE; bcd_out=0 (all digits 0, or per the Optional Feature); neg_out=0; out_valid=0; busy=0.
  - in_ready=0 while reset_n is low; in_valid is ignored.
- FSM states IDLE and SHIFT; iteration counter cnt of width clog2(WIDTH+1).
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&in_ready ("accept edge", E0):
    - Capture mag = (SIGNED && in_value[WIDTH-1]) ? -in_value : in_value, using WIDTH-bit unsigned negation. -2^(WIDTH-1) yields 2^(WIDTH-1) correctly.
    - Capture sign; clear the scratch BCD register; cnt=WIDTH; go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - Each edge: first add 3 to every scratch digit >= 5, then shift {scratch,mag} left by 1 so mag's MSB enters digit 0 bit 0.
  - cnt decrements each edge.
  - At the edge performing the last iteration (E_WIDTH):
    - bcd_out takes the final scratch value, neg_out takes the captured sign.
    - out_valid=1 for exactly the following cycle; state goes to IDLE.
- Latency and throughput:
  - out_valid is high in the cycle after edge E_WIDTH; 16 edges after accept for defaults.
  - The earliest next accept is edge E_WIDTH+1, so throughput is one conversion per WIDTH+1 cycles.
- in_valid during SHIFT: ignored, not captured. The producer holds in_valid until in_ready is seen.
- bcd_out and neg_out hold their last completed result at all times; they never show intermediate scratch values.
- Zero magnitude with sign set cannot occur; neg_out=0 for value 0.
- Reset mid-conversion: conversion aborted, no out_valid pulse, outputs return to reset values.
- Digit values are always 0..9 unless blanked by the Optional Feature.

Optional Feature:
- Macro BCD_BLANK_LEADING_EN.
- When defined:
  - At the completion edge, every leading zero digit above the most-significant nonzero digit is written as 4'hF, which the decoder renders as dark.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Reset value of bcd_out is all 4'hF except digit 0 = 0.
  - neg_out is unaffected.
- When not defined: all digits carry their numeric value, and the reset value is all zeros.

Test Plan:
1. Reset, then accept 16'd0 (SIGNED=0) -> out_valid one cycle 16 edges later. bcd_out=20'h00000 (with BCD_BLANK_LEADING_EN: 20'hFFFF0), neg_out=0.
2. Accept 16'd65535 -> bcd_out=20'h65535. Accept 16'd1007 -> 20'h01007 (blank build: 20'hF1007).
3. SIGNED=1: accept 16'h8000 -> neg_out=1, bcd_out=20'h32768. Accept 16'hFFFF -> neg_out=1, bcd_out=20'h00001. Accept 16'h7FFF -> neg_out=0, bcd_out=20'h32767.
4. Back-to-back:
   - in_valid held with 1234 -> accepted at E0, out_valid after E16, bcd_out=20'h01234.
   - Producer switches to 9 -> accepted at E17, bcd_out=20'h00009 after E33.
   - Value 777 driven mid-SHIFT with in_valid=1 is never captured.
5. Reset mid-operation: drop reset_n at the 8th SHIFT edge of a conversion of 4321 -> no out_valid pulse, bcd_out at reset value, in_ready=1 in the first cycle after reset_n rises.
6. Stability: after completing 40, hold in_valid=0 for 50 cycles -> bcd_out stays 20'h00040 (blank build: 20'hFFF40), out_valid stays 0, in_ready=1.
